computer_boot: RTL and testbench

Parametrised successor to the single-ROM computer top. It instantiates the existing `cpu` and two `ram` instances: a program store and a data store. A boot-loader FSM fills the program store through a valid/ready word stream while the CPU is held in reset, then releases the CPU. It adds a memory-mapped I/O window with `NumOutPorts` output registers and one input port, plus an optional software halt.

---
 rtl/computer_boot_if.sv | 32 +++
 rtl/computer_boot.sv | 257 +++++++++++++++++++++++++
 tb/tb_computer_boot.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/computer_boot_if.sv
// ============================================================================
// computer_boot_if: loader stream, I/O ports and status of computer_boot.
// Revision 1.0
// ============================================================================
`default_nettype none

interface computer_boot_if #(
  parameter int WordSize    = 16,
  parameter int NumOutPorts = 4
) ();
  logic                            load_valid;
  logic [WordSize-1:0]             load_data;
  logic                            load_last;
  logic                            load_ready;
  logic [WordSize-1:0]             in_port;
  logic [NumOutPorts*WordSize-1:0] out_data;
  logic [NumOutPorts-1:0]          out_strobe;
  logic                            running;
  logic                            halted;

  modport master (
    output load_valid, load_data, load_last, in_port,
    input  load_ready, out_data, out_strobe, running, halted
  );

  modport slave (
    input  load_valid, load_data, load_last, in_port,
    output load_ready, out_data, out_strobe, running, halted
  );
endinterface

`default_nettype wire

// File: rtl/computer_boot.sv
// ============================================================================
// computer_boot: boot-loaded Hack-style computer with MMIO ports; optional
// software halt enabled by COMPUTER_BOOT_HALT_EN.  Revision 1.0
// ============================================================================
`default_nettype none

module ram #(
  parameter int AddrSize = 15,
  parameter int WordSize = 16
) (
  input  logic                clk,
  input  logic                load,
  input  logic [AddrSize-1:0] address,
  input  logic [WordSize-1:0] wdata,
  output logic [WordSize-1:0] rdata
);
  logic [WordSize-1:0] mem [0:(1<<AddrSize)-1];

  always_ff @(posedge clk) begin
    if (load) begin
      mem[address] <= wdata;
    end
  end

  // Asynchronous read so the CPU completes a memory access in one cycle.
  assign rdata = mem[address];
endmodule

module cpu #(
  parameter int WordSize     = 16,
  parameter int MemAddrSize  = 15,
  parameter int ProgAddrSize = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WordSize-1:0]     in_m,
  input  logic [WordSize-1:0]     instruction,
  output logic [WordSize-1:0]     out_m,
  output logic                    write_m,
  output logic [MemAddrSize-1:0]  address_m,
  output logic [ProgAddrSize-1:0] pc
);
  logic [WordSize-1:0] a_reg, d_reg;
  logic [WordSize-1:0] alu_x, alu_y, x1, y1, f_out, alu;
  logic                is_c, dest_a, dest_d, zr, ng, jump;
  logic                unused_bits;

  assign is_c        = instruction[WordSize-1];
  assign unused_bits = ^instruction[WordSize-2:13];

  always_comb begin
    alu_x = d_reg;
    alu_y = instruction[12] ? in_m : a_reg;
    x1    = instruction[11] ? '0 : alu_x;
    x1    = instruction[10] ? ~x1 : x1;
    y1    = instruction[9]  ? '0 : alu_y;
    y1    = instruction[8]  ? ~y1 : y1;
    f_out = instruction[7]  ? (x1 + y1) : (x1 & y1);
    alu   = instruction[6]  ? ~f_out : f_out;
  end

  assign zr      = (alu == '0);
  assign ng      = alu[WordSize-1];
  assign dest_a  = is_c & instruction[5];
  assign dest_d  = is_c & instruction[4];
  assign write_m = is_c & instruction[3];
  assign jump    = is_c & ((instruction[2] & ng) | (instruction[1] & zr) |
                           (instruction[0] & ~ng & ~zr));

  assign out_m     = alu;
  assign address_m = a_reg[MemAddrSize-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg <= '0;
      d_reg <= '0;
      pc    <= '0;
    end else begin
      if (!is_c) begin
        a_reg <= instruction;
      end else if (dest_a) begin
        a_reg <= alu;
      end
      if (dest_d) begin
        d_reg <= alu;
      end
      pc <= jump ? a_reg[ProgAddrSize-1:0] : pc + ProgAddrSize'(1);
    end
  end
endmodule

module computer_boot #(
  parameter int MemAddrSize  = 15,
  parameter int ProgAddrSize = 12,
  parameter int WordSize     = 16,
  parameter int NumOutPorts  = 4,
  parameter int IoBase       = (1 << MemAddrSize) - 32
) (
  input  logic           clk,
  input  logic           reset,
  computer_boot_if.slave bus
);
  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam logic [MemAddrSize-1:0] io_base_addr = MemAddrSize'(IoBase);

  state_t                          state, state_next;
  logic [ProgAddrSize-1:0]         load_addr, prog_addr, cpu_pc;
  logic [WordSize-1:0]             instruction, in_m, out_m, dram_rdata, io_rdata;
  logic [MemAddrSize-1:0]          address_m, io_off;
  logic                            write_m, cpu_reset, hold_cpu;
  logic                            ldr_ready, run_flag, halt_flag;
  logic                            load_fire, load_full, prog_we;
  logic                            cpu_write, is_io, ram_we, halt_write;
  logic [NumOutPorts-1:0]          port_sel, strobe;
  logic [NumOutPorts*WordSize-1:0] out_reg;

  assign load_fire = bus.load_valid & ldr_ready;
  assign load_full = (load_addr == '1);
  assign prog_we   = load_fire & ~reset;
  assign prog_addr = run_flag ? cpu_pc : load_addr;
  assign cpu_reset = reset | hold_cpu;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_LOAD;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ldr_ready  = 1'b0;
    run_flag   = 1'b0;
    halt_flag  = 1'b0;
    hold_cpu   = 1'b1;
    case (state)
      ST_LOAD: begin
        ldr_ready = 1'b1;
        if (load_fire && (bus.load_last || load_full)) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        run_flag = 1'b1;
        hold_cpu = 1'b0;
        if (halt_write) begin
          state_next = ST_HALT;
        end
      end
      ST_HALT: begin
`ifdef COMPUTER_BOOT_HALT_EN
        halt_flag = 1'b1;
`endif
        state_next = ST_HALT;
      end
      default: begin
        state_next = ST_LOAD;
      end
    endcase
  end

  // The address saturates at the top of the store; the FSM leaves LOAD there.
  always_ff @(posedge clk) begin
    if (reset) begin
      load_addr <= '0;
    end else if (load_fire && !load_full) begin
      load_addr <= load_addr + ProgAddrSize'(1);
    end
  end

  ram #(.AddrSize(ProgAddrSize), .WordSize(WordSize)) u_prog_ram (
    .clk     (clk),
    .load    (prog_we),
    .address (prog_addr),
    .wdata   (bus.load_data),
    .rdata   (instruction)
  );

  cpu #(.WordSize(WordSize), .MemAddrSize(MemAddrSize), .ProgAddrSize(ProgAddrSize)) u_cpu (
    .clk         (clk),
    .reset       (cpu_reset),
    .in_m        (in_m),
    .instruction (instruction),
    .out_m       (out_m),
    .write_m     (write_m),
    .address_m   (address_m),
    .pc          (cpu_pc)
  );

  assign cpu_write = write_m & run_flag;
  assign is_io     = (address_m >= io_base_addr);
  assign io_off    = address_m - io_base_addr;
  assign ram_we    = cpu_write & ~is_io;

`ifdef COMPUTER_BOOT_HALT_EN
  assign halt_write = cpu_write & is_io & (io_off == MemAddrSize'(NumOutPorts + 1));
`else
  assign halt_write = 1'b0;
`endif

  ram #(.AddrSize(MemAddrSize), .WordSize(WordSize)) u_data_ram (
    .clk     (clk),
    .load    (ram_we),
    .address (address_m),
    .wdata   (out_m),
    .rdata   (dram_rdata)
  );

  always_comb begin
    port_sel = '0;
    for (int k = 0; k < NumOutPorts; k++) begin
      port_sel[k] = cpu_write & is_io & (io_off == MemAddrSize'(k));
    end
  end

  always_comb begin
    io_rdata = '0;
    for (int k = 0; k < NumOutPorts; k++) begin
      if (io_off == MemAddrSize'(k)) begin
        io_rdata = out_reg[k*WordSize +: WordSize];
      end
    end
    if (io_off == MemAddrSize'(NumOutPorts)) begin
      io_rdata = bus.in_port;
    end
  end

  assign in_m = is_io ? io_rdata : dram_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_reg <= '0;
      strobe  <= '0;
    end else begin
      strobe <= port_sel;
      for (int k = 0; k < NumOutPorts; k++) begin
        if (port_sel[k]) begin
          out_reg[k*WordSize +: WordSize] <= out_m;
        end
      end
    end
  end

  assign bus.load_ready = ldr_ready;
  assign bus.running    = run_flag;
  assign bus.halted     = halt_flag;
  assign bus.out_data   = out_reg;
  assign bus.out_strobe = strobe;
endmodule

`default_nettype wire

// File: tb/tb_computer_boot.sv
// ============================================================================
// tb_computer_boot: directed loader / MMIO bench with an I/O-write scoreboard.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_computer_boot;
  localparam int ws  = 16;
  localparam int mas = 8;
  localparam int pas = 5;
  localparam int nop = 4;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  computer_boot_if #(.WordSize(ws), .NumOutPorts(nop)) bus ();

  computer_boot #(
    .MemAddrSize (mas),
    .ProgAddrSize(pas),
    .WordSize    (ws),
    .NumOutPorts (nop)
  ) dut (
    .clk  (clk),
    .reset(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [3:0]  strobe;
    logic [63:0] data;
  } sb_t;
  sb_t sbq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic sb_push(input int cyc, input logic [3:0] stb, input logic [63:0] data);
    sb_t e;
    e.cyc = cyc; e.strobe = stb; e.data = data;
    sbq.push_back(e);
  endtask

  // Called at a falling edge; the word transfers on the following rising edge.
  task automatic send(input logic [15:0] d, input logic lst);
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    bus.load_last  = lst;
    @(negedge clk);
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
  endtask

  // Monitor: every strobe must match the next expected I/O write.
  bit mon_en  = 1'b0;
  int run_cyc = -1;
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.running !== 1'b1) run_cyc = -1;
      else run_cyc++;
      if (bus.out_strobe !== 4'b0000) begin
        if (sbq.size() == 0) begin
          check("unexpected_strobe", 64'(bus.out_strobe), 64'h0);
        end else begin
          sb_t e;
          e = sbq.pop_front();
          check("strobe", 64'(bus.out_strobe), 64'(e.strobe));
          check("out_data", bus.out_data, e.data);
          check("strobe_cycle", 64'(run_cyc), 64'(e.cyc));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  logic [15:0] t1 [0:4];
  logic [15:0] prog [0:31];

  initial begin
    t1   = '{16'h0000, 16'hEA87, 16'h0ABC, 16'h7FFF, 16'h1357};
    prog = '{16'h00AB, 16'hEC10, 16'h00E1, 16'hE308,   // port1 <= 0x00AB
             16'h00E4, 16'hFC10, 16'h0003, 16'hE308,   // RAM[3] <= in_port
             16'h00E6, 16'hFC10, 16'h00E2, 16'hE308,   // port2 <= unmapped read
             16'h0055, 16'hEC10, 16'h00E3, 16'hE308,   // port3 <= 0x55, twice
             16'hE308, 16'h00E5, 16'hE308, 16'h0013,   // write halt address
             16'hEA87, 16'h0000, 16'h0000, 16'h0000,
             16'h0000, 16'h0000, 16'h0000, 16'h0000,
             16'h0000, 16'h0000, 16'h0000, 16'hBEEF};

    rst            = 1'b1;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.load_last  = 1'b0;
    bus.in_port    = 16'h1234;
    repeat (3) @(negedge clk);
    check("rst_load_ready", 64'(bus.load_ready), 64'h1);
    check("rst_running", 64'(bus.running), 64'h0);
    check("rst_halted", 64'(bus.halted), 64'h0);
    check("rst_out_data", bus.out_data, 64'h0);
    check("rst_out_strobe", 64'(bus.out_strobe), 64'h0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Gapped 5-word image terminated by load_last.
    for (int i = 0; i < 5; i++) begin
      if (i == 4) check("pre_last_running", 64'(bus.running), 64'h0);
      send(t1[i], (i == 4));
      if (i < 4) begin
        check("load_running", 64'(bus.running), 64'h0);
        @(negedge clk);
      end
    end
    check("t1_running", 64'(bus.running), 64'h1);
    check("t1_load_ready", 64'(bus.load_ready), 64'h0);
    for (int i = 0; i < 5; i++) check("t1_prog_word", 64'(dut.u_prog_ram.mem[i]), 64'(t1[i]));
    repeat (3) @(negedge clk);
    send(16'hDEAD, 1'b1);
    @(negedge clk);
    check("run_ignores_valid", 64'(dut.u_prog_ram.mem[5] != 16'hDEAD), 64'h1);
    check("t1_still_running", 64'(bus.running), 64'h1);

    // Full-depth image with no load_last; program exercises MMIO.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb_push(4,  4'b0010, 64'h0000_0000_00AB_0000);
    sb_push(12, 4'b0100, 64'h0000_0000_00AB_0000);
    sb_push(16, 4'b1000, 64'h0055_0000_00AB_0000);
    sb_push(17, 4'b1000, 64'h0055_0000_00AB_0000);
    for (int i = 0; i < 32; i++) begin
      if (i == 31) begin
        check("full_pre_ready", 64'(bus.load_ready), 64'h1);
        check("full_pre_running", 64'(bus.running), 64'h0);
      end
      send(prog[i], 1'b0);
    end
    check("full_running", 64'(bus.running), 64'h1);
    check("full_load_ready", 64'(bus.load_ready), 64'h0);
    check("no_wrap_word0", 64'(dut.u_prog_ram.mem[0]), 64'h00AB);
    check("last_word31", 64'(dut.u_prog_ram.mem[31]), 64'hBEEF);
    repeat (18) @(negedge clk);
    check("pre_halt_running", 64'(bus.running), 64'h1);
    check("pre_halt_halted", 64'(bus.halted), 64'h0);
    @(negedge clk);
`ifdef COMPUTER_BOOT_HALT_EN
    check("halt_running", 64'(bus.running), 64'h0);
    check("halt_halted", 64'(bus.halted), 64'h1);
`else
    check("nohalt_running", 64'(bus.running), 64'h1);
    check("nohalt_halted", 64'(bus.halted), 64'h0);
`endif
    repeat (10) @(negedge clk);
`ifdef COMPUTER_BOOT_HALT_EN
    check("halt_sticky", 64'(bus.halted), 64'h1);
    check("halt_load_ready", 64'(bus.load_ready), 64'h0);
`else
    check("nohalt_sticky", 64'(bus.halted), 64'h0);
`endif
    check("out_data_final", bus.out_data, 64'h0055_0000_00AB_0000);
    check("ram3_in_port", 64'(dut.u_data_ram.mem[3]), 64'h1234);
    check("ram_io_shadow", 64'(dut.u_data_ram.mem[225] != 16'h00AB), 64'h1);
    check("sb_drained", 64'(sbq.size()), 64'h0);

    // Reset mid-load, with a word presented on the reset cycle.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send(16'h1111, 1'b0);
    send(16'h2222, 1'b0);
    send(16'h3333, 1'b0);
    rst            = 1'b1;
    bus.load_valid = 1'b1;
    bus.load_data  = 16'h4444;
    @(negedge clk);
    rst            = 1'b0;
    bus.load_valid = 1'b0;
    check("mid_out_data", bus.out_data, 64'h0);
    check("mid_running", 64'(bus.running), 64'h0);
    check("mid_halted", 64'(bus.halted), 64'h0);
    check("mid_load_ready", 64'(bus.load_ready), 64'h1);
    check("reset_blocks_write", 64'(dut.u_prog_ram.mem[3]), 64'hE308);
    send(16'h0000, 1'b0);
    check("reload_running", 64'(bus.running), 64'h0);
    check("reload_out_data", bus.out_data, 64'h0);
    send(16'hEA87, 1'b1);
    check("reload_run", 64'(bus.running), 64'h1);
    check("reload_word0", 64'(dut.u_prog_ram.mem[0]), 64'h0000);
    check("reload_word1", 64'(dut.u_prog_ram.mem[1]), 64'hEA87);
    check("reload_word2", 64'(dut.u_prog_ram.mem[2]), 64'h3333);
    repeat (5) @(negedge clk);
    check("reload_still_running", 64'(bus.running), 64'h1);
    check("sb_final", 64'(sbq.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
